// File: rtl/adc_acq_sequencer.sv
// adc_acq_sequencer
// Periodic acquisition scheduler for the SPI ADC -> filter -> comparator chain.
// Issues start_conversion at a fixed rate, walks each sample through the three
// done handshakes, and guards every wait with a watchdog. It also flags samples
// that finish late (overrun) and counts completed samples.
module adc_acq_sequencer #(
    parameter int SAMPLE_PERIOD = 1000,
    parameter int TIMEOUT       = 255,
    parameter int PCNT_W        = 16,
    parameter int TCNT_W        = 8,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_enable,
    input  logic             single_shot,
    input  logic             clear_err,
    input  logic             data_ready,
    input  logic             filter_done,
    input  logic             compare_done,
    output logic             start_conversion,
    output logic             filter_enable,
    output logic             compare_enable,
    output logic             busy,
    output logic             cycle_done,
    output logic             timeout_err,
    output logic             overrun,
    output logic [CNT_W-1:0] sample_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIGGER,
        ST_WAIT_ADC,
        ST_FILTER,
        ST_COMPARE,
        ST_HOLDOFF,
        ST_ERROR
    } state_e;

    // pcnt reads 0 during the TRIGGER cycle, so PERIOD_END means the period expired
    localparam logic [PCNT_W-1:0] PERIOD_END  = PCNT_W'(SAMPLE_PERIOD);
    localparam logic [PCNT_W-1:0] PERIOD_LAST = PCNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST   = TCNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              cycle_done_q, cycle_done_d;
    logic              timeout_err_q, timeout_err_d;
    logic              overrun_q, overrun_d;
    logic              stage_done;

    // Select the done handshake that the current waiting state listens to
    always_comb begin
        stage_done = 1'b0;
        case (state_q)
            ST_WAIT_ADC: stage_done = data_ready;
            ST_FILTER:   stage_done = filter_done;
            ST_COMPARE:  stage_done = compare_done;
            default:     stage_done = 1'b0;
        endcase
    end

    // Next-state, watchdog, sample counting and sticky flag logic
    always_comb begin
        state_d       = state_q;
        tcnt_d        = '0;
        count_d       = count_q;
        cycle_done_d  = 1'b0;
        timeout_err_d = timeout_err_q;
        overrun_d     = clear_err ? 1'b0 : overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (run_enable || single_shot) begin
                    state_d = ST_TRIGGER;
                end
            end

            ST_TRIGGER: begin
                state_d = ST_WAIT_ADC;
            end

            ST_WAIT_ADC, ST_FILTER, ST_COMPARE: begin
                if (stage_done) begin
                    if (state_q == ST_WAIT_ADC) begin
                        state_d = ST_FILTER;
                    end else if (state_q == ST_FILTER) begin
                        state_d = ST_COMPARE;
                    end else begin
                        cycle_done_d = 1'b1;
                        count_d      = count_q + 1'b1;
                        if (pcnt_q == PERIOD_END) begin
                            overrun_d = 1'b1;
                        end
                        if (run_enable && (pcnt_q >= PERIOD_LAST)) begin
                            state_d = ST_TRIGGER;
                        end else if (run_enable) begin
                            state_d = ST_HOLDOFF;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else if (tcnt_q == TCNT_LAST) begin
                    state_d       = ST_ERROR;
                    timeout_err_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end

            ST_HOLDOFF: begin
                if (!run_enable) begin
                    state_d = ST_IDLE;
                end else if (pcnt_q == PERIOD_LAST) begin
                    state_d = ST_TRIGGER;
                end
            end

            ST_ERROR: begin
                if (clear_err) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b0;
                    overrun_d     = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Period counter: zero in the TRIGGER cycle, then counts up and saturates
    always_comb begin
        pcnt_d = pcnt_q;
        if (state_d == ST_TRIGGER) begin
            pcnt_d = '0;
        end else if (pcnt_q != PERIOD_END) begin
            pcnt_d = pcnt_q + 1'b1;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            pcnt_q        <= '0;
            tcnt_q        <= '0;
            count_q       <= '0;
            cycle_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pcnt_q        <= pcnt_d;
            tcnt_q        <= tcnt_d;
            count_q       <= count_d;
            cycle_done_q  <= cycle_done_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign start_conversion = (state_q == ST_TRIGGER);
    assign filter_enable    = (state_q == ST_FILTER);
    assign compare_enable   = (state_q == ST_COMPARE);
    assign busy             = (state_q != ST_IDLE) && (state_q != ST_ERROR);
    assign cycle_done       = cycle_done_q;
    assign timeout_err      = timeout_err_q;
    assign overrun          = overrun_q;
    assign sample_count     = count_q;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// tb_adc_acq_sequencer
// Bench for the acquisition sequencer. A responder answers the done handshakes
// with programmable delays; every completed sample is predicted when
// compare_done is driven and checked when cycle_done appears.
module tb_adc_acq_sequencer;

    localparam int PERIOD = 20;
    localparam int TMO    = 8;

    localparam int W_START = 0;
    localparam int W_IDLE  = 1;
    localparam int W_FEN   = 2;
    localparam int W_CEN   = 3;
    localparam int W_TERR  = 4;

    logic        clk;
    logic        reset;
    logic        run_enable;
    logic        single_shot;
    logic        clear_err;
    logic        data_ready   = 1'b0;
    logic        filter_done  = 1'b0;
    logic        compare_done = 1'b0;
    logic        start_conversion;
    logic        filter_enable;
    logic        compare_enable;
    logic        busy;
    logic        cycle_done;
    logic        timeout_err;
    logic        overrun;
    logic [15:0] sample_count;

    typedef struct {
        int count;
        bit ovr;
    } exp_t;

    exp_t sb[$];

    int nChecks    = 0;
    int nPass      = 0;
    int cyc        = 0;
    int trigCount  = 0;
    int cdCount    = 0;
    int adcDelay   = 2;
    int filtDelay  = 2;
    int cmpDelay   = 2;
    bit adcActive  = 1'b0;
    int adcCnt     = 0;
    int fCnt       = 0;
    int cCnt       = 0;
    int tbPcnt     = PERIOD;
    int modelCount = 0;
    bit modelOvr   = 1'b0;

    adc_acq_sequencer #(
        .SAMPLE_PERIOD(PERIOD),
        .TIMEOUT      (TMO),
        .PCNT_W       (16),
        .TCNT_W       (8),
        .CNT_W        (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .run_enable      (run_enable),
        .single_shot     (single_shot),
        .clear_err       (clear_err),
        .data_ready      (data_ready),
        .filter_done     (filter_done),
        .compare_done    (compare_done),
        .start_conversion(start_conversion),
        .filter_enable   (filter_enable),
        .compare_enable  (compare_enable),
        .busy            (busy),
        .cycle_done      (cycle_done),
        .timeout_err     (timeout_err),
        .overrun         (overrun),
        .sample_count    (sample_count)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single point of comparison: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Responder and scoreboard, sampled 1 unit after each rising edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        data_ready   = 1'b0;
        filter_done  = 1'b0;
        compare_done = 1'b0;
        if (!reset) begin
            adcActive  = 1'b0;
            fCnt       = 0;
            cCnt       = 0;
            tbPcnt     = PERIOD;
            modelCount = 0;
            modelOvr   = 1'b0;
            sb.delete();
        end else begin
            if (start_conversion) begin
                trigCount++;
                tbPcnt = 0;
            end else if (tbPcnt < PERIOD) begin
                tbPcnt++;
            end
            if (clear_err) modelOvr = 1'b0;

            if (cycle_done) begin
                cdCount++;
                if (sb.size() == 0) begin
                    checkOutput("sb_unexpected_cycle_done", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    checkOutput("sb_count", 32'(sample_count), 32'(e.count));
                    checkOutput("sb_overrun", 32'(overrun), 32'(e.ovr));
                end
            end

            if (!busy) adcActive = 1'b0;
            if (adcActive) begin
                if (adcCnt == adcDelay) begin
                    data_ready = 1'b1;
                    adcActive  = 1'b0;
                end else begin
                    adcCnt++;
                end
            end
            if (start_conversion) begin
                adcActive = 1'b1;
                adcCnt    = 0;
            end

            if (filter_enable) begin
                if (fCnt == filtDelay) filter_done = 1'b1;
                fCnt++;
            end else begin
                fCnt = 0;
            end

            if (compare_enable) begin
                if (cCnt == cmpDelay) begin
                    compare_done = 1'b1;
                    modelCount   = (modelCount + 1) % 65536;
                    if (tbPcnt == PERIOD) modelOvr = 1'b1;
                    sb.push_back('{modelCount, modelOvr});
                end
                cCnt++;
            end else begin
                cCnt = 0;
            end
        end
    end

    // Advance to 2 units after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Drive the control inputs for one cycle; pulse inputs drop afterwards
    task automatic applyStimulus(input logic run, input logic single, input logic clr);
        run_enable  = run;
        single_shot = single;
        clear_err   = clr;
        tick();
        single_shot = 1'b0;
        clear_err   = 1'b0;
    endtask

    task automatic applyReset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    function automatic bit sigSel(input int which);
        case (which)
            W_START: return start_conversion;
            W_IDLE:  return !busy;
            W_FEN:   return filter_enable;
            W_CEN:   return compare_enable;
            W_TERR:  return timeout_err;
            default: return 1'b0;
        endcase
    endfunction

    // Bounded wait for a condition; an expired bound is a failed check
    task automatic waitFor(input string tag, input int which, input int maxC, output int whenC);
        bit found;
        found = 1'b0;
        whenC = -1;
        for (int i = 0; i < maxC && !found; i++) begin
            tick();
            if (sigSel(which)) begin
                found = 1'b1;
                whenC = cyc;
            end
        end
        checkOutput({tag, "_seen"}, 32'(found), 32'(1));
    endtask

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        int t0, t1, t2, t3, t, w, trigBase, cdBase;
        reset       = 1'b0;
        run_enable  = 1'b0;
        single_shot = 1'b0;
        clear_err   = 1'b0;
        tick();
        tick();
        checkOutput("rst_outputs", 32'({start_conversion, filter_enable, compare_enable, busy,
                                        cycle_done, timeout_err, overrun}), 32'(0));
        checkOutput("rst_count", 32'(sample_count), 32'(0));
        reset = 1'b1;
        tick();

        $display("[TB] continuous acquisition");
        run_enable = 1'b1;
        waitFor("t1_start0", W_START, 5, t0);
        tick();
        checkOutput("t1_start_pulse_width", 32'(start_conversion), 32'(0));
        waitFor("t1_start1", W_START, 30, t1);
        checkOutput("t1_spacing1", t1 - t0, PERIOD);
        tick();
        waitFor("t1_start2", W_START, 30, t2);
        checkOutput("t1_spacing2", t2 - t1, PERIOD);
        tick();
        waitFor("t1_start3", W_START, 30, t3);
        checkOutput("t1_spacing3", t3 - t2, PERIOD);
        checkOutput("t1_count_after_3", 32'(sample_count), 32'(3));
        checkOutput("t1_overrun", 32'(overrun), 32'(0));
        run_enable = 1'b0;
        waitFor("t1_idle", W_IDLE, 30, w);
        checkOutput("t1_final_count", 32'(sample_count), 32'(4));

        $display("[TB] single shot");
        applyReset();
        trigBase = trigCount;
        cdBase   = cdCount;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t2_start", 32'(start_conversion), 32'(1));
        repeat (3) tick();
        checkOutput("t2_busy", 32'(busy), 32'(1));
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitFor("t2_idle", W_IDLE, 30, w);
        repeat (25) tick();
        checkOutput("t2_triggers", trigCount - trigBase, 1);
        checkOutput("t2_cycle_done", cdCount - cdBase, 1);
        checkOutput("t2_count", 32'(sample_count), 32'(1));
        checkOutput("t2_busy_end", 32'(busy), 32'(0));

        $display("[TB] ADC timeout");
        applyReset();
        adcDelay = -1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        t = cyc;
        checkOutput("t3a_start", 32'(start_conversion), 32'(1));
        run_enable = 1'b1;
        waitFor("t3a_err", W_TERR, 20, w);
        checkOutput("t3a_err_latency", w - t, TMO + 1);
        checkOutput("t3a_busy", 32'(busy), 32'(0));
        trigBase = trigCount;
        repeat (20) tick();
        checkOutput("t3a_no_trigger", trigCount - trigBase, 0);
        checkOutput("t3a_sticky", 32'(timeout_err), 32'(1));
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t3a_cleared", 32'(timeout_err), 32'(0));
        tick();
        checkOutput("t3a_idle", 32'(busy), 32'(0));

        $display("[TB] filter timeout");
        adcDelay  = 2;
        filtDelay = -1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        t = cyc;
        waitFor("t3b_err", W_TERR, 30, w);
        checkOutput("t3b_err_latency", w - t, 4 + TMO);
        checkOutput("t3b_filter_enable", 32'(filter_enable), 32'(0));
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t3b_cleared", 32'(timeout_err), 32'(0));

        $display("[TB] late-done boundary and overrun");
        applyReset();
        filtDelay  = TMO - 1;
        adcDelay   = TMO - 1;
        cmpDelay   = 2;
        run_enable = 1'b1;
        waitFor("t5_start0", W_START, 5, t0);
        tick();
        waitFor("t5_start1", W_START, 30, t1);
        checkOutput("t5_spacing_on_time", t1 - t0, PERIOD);
        checkOutput("t5_no_overrun", 32'(overrun), 32'(0));
        cmpDelay = TMO - 1;
        tick();
        waitFor("t5_start2", W_START, 40, t2);
        checkOutput("t5_spacing_late", t2 - t1, 25);
        checkOutput("t4_no_timeout", 32'(timeout_err), 32'(0));
        checkOutput("t5_overrun", 32'(overrun), 32'(1));
        run_enable = 1'b0;
        waitFor("t5_idle", W_IDLE, 60, w);
        checkOutput("t5_count", 32'(sample_count), 32'(3));
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t5_overrun_cleared", 32'(overrun), 32'(0));
        checkOutput("t5_idle_after_clear", 32'(busy), 32'(0));

        $display("[TB] run drop and mid-sample reset");
        applyReset();
        adcDelay   = 2;
        filtDelay  = 2;
        cmpDelay   = 2;
        run_enable = 1'b1;
        waitFor("t6_filter", W_FEN, 10, w);
        run_enable = 1'b0;
        waitFor("t6_idle", W_IDLE, 20, w);
        checkOutput("t6_count", 32'(sample_count), 32'(1));
        trigBase = trigCount;
        repeat (25) tick();
        checkOutput("t6_no_retrigger", trigCount - trigBase, 0);
        run_enable = 1'b1;
        waitFor("t6_compare", W_CEN, 20, w);
        checkOutput("t6_count_pre_reset", 32'(sample_count), 32'(1));
        reset = 1'b0;
        #1;
        checkOutput("t6_rst_compare_enable", 32'(compare_enable), 32'(0));
        checkOutput("t6_rst_count", 32'(sample_count), 32'(0));
        checkOutput("t6_rst_busy", 32'(busy), 32'(0));
        run_enable = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checkOutput("t6_post_reset_count", 32'(sample_count), 32'(0));

        checkOutput("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
